// File: rtl/id_regfile_fwd_pkg.sv
// Shared definitions for the ID-stage register file with forwarding.
// Contents: the zero-register address, default width parameters and the
// per-read-port data-source enumeration produced by fwd_sel.
// Optional feature macro: REGFILE_BYPASS_EN (EX/MEM forwarding; see top).
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // Where a read port takes its data from, youngest stage first.
  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_EX,
    SRC_MEM,
    SRC_WB,
    SRC_RF
  } src_e;

endpackage

// File: rtl/id_regfile_fwd_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
// Carries the WB write port, EX/MEM destination tuples, the packed read
// ports, read data, stall request and the stall counter with its clear.
interface id_regfile_fwd_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 16
);
  logic                     wb_we_i;
  logic [ADDR_W-1:0]        wb_waddr_i;
  logic [DATA_W-1:0]        wb_wdata_i;
  logic                     ex_we_i;
  logic [ADDR_W-1:0]        ex_waddr_i;
  logic [DATA_W-1:0]        ex_wdata_i;
  logic                     ex_is_load_i;
  logic                     mem_we_i;
  logic [ADDR_W-1:0]        mem_waddr_i;
  logic [DATA_W-1:0]        mem_wdata_i;
  logic [NUM_RD-1:0]        re_i;
  logic [NUM_RD*ADDR_W-1:0] raddr_i;
  logic [NUM_RD*DATA_W-1:0] rdata_o;
  logic                     stall_req_o;
  logic                     clr_cnt_i;
  logic [CNT_W-1:0]         stall_cnt_o;

  modport master (
    output wb_we_i, wb_waddr_i, wb_wdata_i,
    output ex_we_i, ex_waddr_i, ex_wdata_i, ex_is_load_i,
    output mem_we_i, mem_waddr_i, mem_wdata_i,
    output re_i, raddr_i, clr_cnt_i,
    input  rdata_o, stall_req_o, stall_cnt_o
  );

  modport slave (
    input  wb_we_i, wb_waddr_i, wb_wdata_i,
    input  ex_we_i, ex_waddr_i, ex_wdata_i, ex_is_load_i,
    input  mem_we_i, mem_waddr_i, mem_wdata_i,
    input  re_i, raddr_i, clr_cnt_i,
    output rdata_o, stall_req_o, stall_cnt_o
  );
endinterface

// File: rtl/id_regfile_fwd_fwd_sel.sv
// fwd_sel: per-read-port source selection and hazard detection.
// Inputs : re/raddr of one port, EX (we, waddr, is_load), MEM (we, waddr),
//          WB (we, waddr).
// Outputs: src (data source enum), hazard (this port must stall ID).
// REGFILE_BYPASS_EN defined  : EX > MEM > WB > RF, stall only on load-use.
// REGFILE_BYPASS_EN undefined: WB > RF, stall on any EX or MEM RAW match.
module fwd_sel
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  output src_e              src,
  output logic              hazard
);

  // raddr != 0 is folded into every hit, so a stage writing r0 never matches.
  logic rd_ok, ex_hit, mem_hit, wb_hit;
  assign rd_ok   = re && (raddr != ADDR_W'(REG_ZERO));
  assign ex_hit  = rd_ok && ex_we  && (ex_waddr  == raddr);
  assign mem_hit = rd_ok && mem_we && (mem_waddr == raddr);
  assign wb_hit  = rd_ok && wb_we  && (wb_waddr  == raddr);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    src = SRC_RF;
    if (!rd_ok)       src = SRC_ZERO;
    else if (ex_hit)  src = SRC_EX;
    else if (mem_hit) src = SRC_MEM;
    else if (wb_hit)  src = SRC_WB;
  end
  // Only a load in EX lacks its result; everything else is forwarded.
  assign hazard = ex_hit && ex_is_load;
`else
  always_comb begin
    src = SRC_RF;
    if (!rd_ok)      src = SRC_ZERO;
    else if (wb_hit) src = SRC_WB;
  end
  // Full interlock: any in-flight producer holds ID until it reaches WB.
  assign hazard = ex_hit || mem_hit;
  logic unused_load;
  assign unused_load = ex_is_load;
`endif

endmodule

// File: rtl/id_regfile_fwd.sv
// id_regfile_fwd: ID-stage register file, NUM_RD read ports, one WB write
// port, EX/MEM/WB forwarding, load-use detection and a saturating stall
// counter.
// Ports: clk, rst (async, active-high), bus (id_regfile_fwd_if.slave).
// Optional feature macro: REGFILE_BYPASS_EN enables EX/MEM forwarding;
// without it only WB write-through remains and any EX/MEM RAW stalls.
module id_regfile_fwd
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  id_regfile_fwd_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]             rf [DEPTH];
  logic [NUM_RD-1:0][DATA_W-1:0] rd;
  logic [NUM_RD-1:0]             hazard;
  logic                          stall;
  logic [CNT_W-1:0]              cnt;

  // Storage; r0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (bus.wb_we_i && bus.wb_waddr_i != ADDR_W'(REG_ZERO)) begin
      rf[bus.wb_waddr_i] <= bus.wb_wdata_i;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] raddr;
    src_e              src;
    logic [DATA_W-1:0] d;

    assign raddr = bus.raddr_i[k*ADDR_W +: ADDR_W];

    fwd_sel #(.ADDR_W(ADDR_W)) u_sel (
      .re        (bus.re_i[k]),
      .raddr     (raddr),
      .ex_we     (bus.ex_we_i),
      .ex_waddr  (bus.ex_waddr_i),
      .ex_is_load(bus.ex_is_load_i),
      .mem_we    (bus.mem_we_i),
      .mem_waddr (bus.mem_waddr_i),
      .wb_we     (bus.wb_we_i),
      .wb_waddr  (bus.wb_waddr_i),
      .src       (src),
      .hazard    (hazard[k])
    );

    always_comb begin
      d = '0;
      case (src)
`ifdef REGFILE_BYPASS_EN
        SRC_EX:  d = bus.ex_wdata_i;
        SRC_MEM: d = bus.mem_wdata_i;
`endif
        SRC_WB:  d = bus.wb_wdata_i;
        SRC_RF:  d = rf[raddr];
        default: d = '0;
      endcase
    end

    assign rd[k] = d;
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_nobypass;
  assign unused_nobypass = ^{bus.ex_wdata_i, bus.mem_wdata_i};
`endif

  // Forwarded stage data bypasses the cleared array, so gate it during reset.
  assign stall           = ~rst & (|hazard);
  assign bus.stall_req_o = stall;
  assign bus.rdata_o     = rst ? '0 : rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (bus.clr_cnt_i)       cnt <= '0;
    else if (stall && cnt != '1)  cnt <= cnt + 1'b1;
  end

  assign bus.stall_cnt_o = cnt;

endmodule
